// File: rtl/uart_rx_deser_param.sv
// UART receive deserializer: captures DATA_WIDTH bits (plus an optional parity
// bit) on sample strobes after a start pulse, then presents the word with a
// one-cycle valid pulse.
module uart_rx_deser_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sample_en,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  busy
);

  localparam int unsigned CW      = $clog2(DATA_WIDTH + 1);
  localparam logic        ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  last_bit;
  logic                  capture;
  logic                  finish;

  assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

  // Shift register with the incoming bit inserted at the end matching bit order.
  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST != 0) begin
      shreg_nxt = {shreg[DATA_WIDTH-2:0], data_in};
    end else begin
      shreg_nxt = {data_in, shreg[DATA_WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; finish marks the final capturing strobe so the result
  // registers on that edge and appears (with busy low) in the following cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (sample_en) begin
          capture = 1'b1;
          if (last_bit) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
            end else begin
              state_nxt = IDLE;
              finish    = 1'b1;
            end
          end
        end
      end
      PARITY: begin
        busy = 1'b1;
        if (sample_en) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: bit counter, shift register and held result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '1;
      cnt        <= '0;
      data_out   <= '1;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      data_valid <= finish;
      if (state == IDLE && start) begin
        shreg <= '1;
        cnt   <= '0;
      end else if (capture) begin
        shreg <= shreg_nxt;
        cnt   <= cnt + 1'b1;
      end
      if (finish) begin
        if (PARITY_EN != 0) begin
          data_out   <= shreg;
          parity_err <= (^shreg) ^ data_in ^ ODD_BIT;
        end else begin
          data_out   <= shreg_nxt;
          parity_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Testbench for uart_rx_deser_param: five instances in different configurations,
// scoreboard queue of expected words popped when data_valid is observed.
module tb_uart_rx_deser_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] st = '0;
  logic [4:0] se = '0;
  logic [4:0] di = '1;
  logic [4:0] dv, pe, bz;
  logic [8:0] dq [5];

  logic [7:0] d0, d1, d4;
  logic [6:0] d2;
  logic [8:0] d3;

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       p;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         vcnt[5] = '{0, 0, 0, 0, 0};
  int         pushed[5] = '{0, 0, 0, 0, 0};
  int         widths[5] = '{8, 8, 7, 9, 8};
  logic [8:0] last_d;
  logic       last_p;

  always #5 clk = ~clk;

  // 0: 8N LSB-first, 1: 8N MSB-first, 2: 7E LSB-first, 3: 9N LSB-first, 4: 8O MSB-first
  uart_rx_deser_param u0 (.clk(clk), .reset(reset), .start(st[0]), .sample_en(se[0]),
    .data_in(di[0]), .data_out(d0), .data_valid(dv[0]), .parity_err(pe[0]), .busy(bz[0]));
  uart_rx_deser_param #(.MSB_FIRST(1)) u1 (.clk(clk), .reset(reset), .start(st[1]),
    .sample_en(se[1]), .data_in(di[1]), .data_out(d1), .data_valid(dv[1]),
    .parity_err(pe[1]), .busy(bz[1]));
  uart_rx_deser_param #(.DATA_WIDTH(7), .PARITY_EN(1), .PARITY_ODD(0)) u2 (.clk(clk),
    .reset(reset), .start(st[2]), .sample_en(se[2]), .data_in(di[2]), .data_out(d2),
    .data_valid(dv[2]), .parity_err(pe[2]), .busy(bz[2]));
  uart_rx_deser_param #(.DATA_WIDTH(9)) u3 (.clk(clk), .reset(reset), .start(st[3]),
    .sample_en(se[3]), .data_in(di[3]), .data_out(d3), .data_valid(dv[3]),
    .parity_err(pe[3]), .busy(bz[3]));
  uart_rx_deser_param #(.MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u4 (.clk(clk),
    .reset(reset), .start(st[4]), .sample_en(se[4]), .data_in(di[4]), .data_out(d4),
    .data_valid(dv[4]), .parity_err(pe[4]), .busy(bz[4]));

  assign dq[0] = {1'b0, d0};
  assign dq[1] = {1'b0, d1};
  assign dq[2] = {2'b0, d2};
  assign dq[3] = d3;
  assign dq[4] = {1'b0, d4};

  // Count every valid pulse so spurious or stretched pulses are visible.
  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (dv[k] === 1'b1) vcnt[k] <= vcnt[k] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [8:0] word, input bit par_en,
                          input bit odd, input logic pbit);
    exp_t       e;
    logic [8:0] m;
    m = word & ((9'h1 << widths[k]) - 9'h1);
    e.k = k;
    e.d = m;
    e.p = par_en ? ((^m) ^ pbit ^ odd) : 1'b0;
    exp_q.push_back(e);
    pushed[k]++;
  endtask

  task automatic strobe(input int k, input logic b, input int gap);
    di[k] = b;
    se[k] = 1'b1;
    tick();
    se[k] = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_start(input int k);
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
  endtask

  // Send data bits lo..hi-1 in wire order; the very last strobe is left tight
  // when tight_end is set so the result is due in the current cycle.
  task automatic send_bits(input int k, input logic [8:0] word, input bit msb,
                           input int lo, input int hi, input bit tight_end);
    int   w;
    logic b;
    w = widths[k];
    for (int i = lo; i < hi; i++) begin
      b = msb ? word[w-1-i] : word[i];
      strobe(k, b, (tight_end && i == hi - 1) ? 0 : int'($urandom_range(0, 2)));
    end
  endtask

  // Result must be present exactly now (one cycle after the last strobe).
  task automatic check_out(input int k, input string nm);
    exp_t e;
    int   waited;
    waited = 0;
    while (dv[k] !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (dv[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s valid: got no pulse in 20 cycles, want pulse", nm);
      return;
    end
    n_cmp++;
    if (waited != 0) begin
      n_bad++;
      $display("FAIL %s latency: got %0d extra cycles, want 0", nm, waited);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s scoreboard: got valid with empty queue, want queued entry", nm);
      return;
    end
    e = exp_q.pop_front();
    last_d = e.d;
    last_p = e.p;
    n_cmp++;
    if (e.k != k) begin
      n_bad++;
      $display("FAIL %s instance: got %0d, want %0d", nm, k, e.k);
    end
    n_cmp++;
    if (dq[k] !== e.d) begin
      n_bad++;
      $display("FAIL %s data_out: got %h, want %h", nm, dq[k], e.d);
    end
    n_cmp++;
    if (pe[k] !== e.p) begin
      n_bad++;
      $display("FAIL %s parity_err: got %b, want %b", nm, pe[k], e.p);
    end
    n_cmp++;
    if (bz[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy in completion: got %b, want 0", nm, bz[k]);
    end
  endtask

  // Following cycle: valid has dropped and results are held.
  task automatic check_gap(input int k, input string nm);
    tick();
    n_cmp++;
    if (dv[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s valid width: got %b, want 0", nm, dv[k]);
    end
    n_cmp++;
    if (dq[k] !== last_d || pe[k] !== last_p) begin
      n_bad++;
      $display("FAIL %s hold: got %h/%b, want %h/%b", nm, dq[k], pe[k], last_d, last_p);
    end
  endtask

  task automatic run_frame(input int k, input logic [8:0] word, input bit msb,
                           input bit par_en, input bit odd, input logic pbit,
                           input string nm);
    push_exp(k, word, par_en, odd, pbit);
    pulse_start(k);
    send_bits(k, word, msb, 0, widths[k], !par_en);
    if (par_en) strobe(k, pbit, 0);
    check_out(k, nm);
    check_gap(k, nm);
  endtask

  task automatic test_reset();
    logic [8:0] ones;
    reset = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      ones = (9'h1 << widths[k]) - 9'h1;
      n_cmp++;
      if (dq[k] !== ones) begin
        n_bad++;
        $display("FAIL reset data_out[%0d]: got %h, want %h", k, dq[k], ones);
      end
      n_cmp++;
      if (dv[k] !== 1'b0 || pe[k] !== 1'b0 || bz[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset flags[%0d]: got v%b p%b b%b, want 000", k, dv[k], pe[k], bz[k]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lsb();
    run_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, "lsb_a5");
    run_frame(0, 9'h001, 1'b0, 1'b0, 1'b0, 1'b0, "lsb_01");
    run_frame(0, 9'h0E8, 1'b0, 1'b0, 1'b0, 1'b0, "lsb_e8");
  endtask

  task automatic test_msb();
    run_frame(1, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, "msb_a5");
    run_frame(1, 9'h05A, 1'b1, 1'b0, 1'b0, 1'b0, "msb_5a");
    run_frame(1, 9'h0C1, 1'b1, 1'b0, 1'b0, 1'b0, "msb_c1");
  endtask

  task automatic test_parity();
    run_frame(2, 9'h041, 1'b0, 1'b1, 1'b0, 1'b0, "even_ok");
    run_frame(2, 9'h041, 1'b0, 1'b1, 1'b0, 1'b1, "even_bad");
    run_frame(2, 9'h007, 1'b0, 1'b1, 1'b0, 1'b1, "even_ok3");
    run_frame(4, 9'h0A5, 1'b1, 1'b1, 1'b1, 1'b1, "odd_ok");
    run_frame(4, 9'h0A5, 1'b1, 1'b1, 1'b1, 1'b0, "odd_bad");
    run_frame(4, 9'h031, 1'b1, 1'b1, 1'b1, 1'b0, "odd_ok3");
  endtask

  task automatic test_start_with_sample();
    push_exp(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    st[0] = 1'b1;
    se[0] = 1'b1;
    di[0] = 1'b0;
    tick();
    st[0] = 1'b0;
    se[0] = 1'b0;
    send_bits(0, 9'h03C, 1'b0, 0, 8, 1'b1);
    check_out(0, "start_sample");
    check_gap(0, "start_sample");
  endtask

  task automatic test_start_while_busy();
    push_exp(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
    pulse_start(0);
    send_bits(0, 9'h0C3, 1'b0, 0, 4, 1'b0);
    pulse_start(0);
    n_cmp++;
    if (bz[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_start busy: got %b, want 1", bz[0]);
    end
    send_bits(0, 9'h0C3, 1'b0, 4, 8, 1'b1);
    check_out(0, "busy_start");
    check_gap(0, "busy_start");
  endtask

  task automatic test_back_to_back();
    push_exp(0, 9'h096, 1'b0, 1'b0, 1'b0);
    pulse_start(0);
    send_bits(0, 9'h096, 1'b0, 0, 8, 1'b1);
    st[0] = 1'b1;
    check_out(0, "b2b_first");
    tick();
    st[0] = 1'b0;
    n_cmp++;
    if (bz[0] !== 1'b1 || dv[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b restart: got busy %b valid %b, want 1 0", bz[0], dv[0]);
    end
    push_exp(0, 9'h069, 1'b0, 1'b0, 1'b0);
    send_bits(0, 9'h069, 1'b0, 0, 8, 1'b1);
    check_out(0, "b2b_second");
    check_gap(0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int v0;
    pulse_start(0);
    send_bits(0, 9'h0F0, 1'b0, 0, 3, 1'b0);
    v0 = vcnt[0];
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bz[0] !== 1'b0 || dq[0] !== 9'h0FF || dv[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid state: got busy %b data %h valid %b, want 0 0ff 0",
               bz[0], dq[0], dv[0]);
    end
    tick();
    reset = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (vcnt[0] != v0) begin
      n_bad++;
      $display("FAIL reset_mid valid count: got %0d, want %0d", vcnt[0], v0);
    end
    run_frame(0, 9'h081, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_next");
  endtask

  task automatic test_held_strobe();
    int v0;
    v0 = vcnt[3];
    push_exp(3, 9'h1FF, 1'b0, 1'b0, 1'b0);
    pulse_start(3);
    di[3] = 1'b1;
    se[3] = 1'b1;
    repeat (9) tick();
    se[3] = 1'b0;
    check_out(3, "held_9");
    check_gap(3, "held_9");
    repeat (3) tick();
    n_cmp++;
    if (vcnt[3] != v0 + 1) begin
      n_bad++;
      $display("FAIL held_9 valid count: got %0d, want %0d", vcnt[3] - v0, 1);
    end
    run_frame(3, 9'h12D, 1'b0, 1'b0, 1'b0, 1'b0, "w9_12d");
  endtask

  task automatic test_final();
    repeat (4) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard left: got %0d entries, want 0", exp_q.size());
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (vcnt[k] != pushed[k]) begin
        n_bad++;
        $display("FAIL valid total[%0d]: got %0d, want %0d", k, vcnt[k], pushed[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_msb();
    test_parity();
    test_start_with_sample();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_held_strobe();
    test_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser_param.md
Name: uart_rx_deser_param

Overview:
- Parametrised UART receive deserializer.
- Captures DATA_WIDTH serial bits plus an optional parity bit, framed by a start strobe and clocked in by a per-bit sample strobe from the Rx oversampler.
- Shifts LSB-first or MSB-first, checks parity, and presents the result as a held parallel word with a one-cycle valid pulse to the Rx frame controller.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
- MSB_FIRST, 0, 0 = first received bit is data_out[0]; 1 = first received bit is data_out[DATA_WIDTH-1].
- PARITY_EN, 0, 1 = one parity bit is captured after the data bits.
- PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse from the frame controller after the start bit is validated.
- sample_en  input  1  one-cycle strobe at mid-bit; data_in is valid when high.
- data_in  input  1  synchronised serial Rx line.
- data_out  output  DATA_WIDTH  last completed word; held until the next completion.
- data_valid  output  1  one-cycle pulse when data_out/parity_err update.
- parity_err  output  1  parity mismatch of the last completed frame; held; 0 when PARITY_EN=0.
- busy  output  1  high while a frame is being captured.

Behaviour:
- Reset (asynchronous, on reset high):
  - Internal shift register = all ones (idle line level).
  - data_out = all ones.
  - bit counter = 0, state = IDLE.
  - data_valid = 0, parity_err = 0, busy = 0.
- States: IDLE, DATA, PARITY.
- IDLE:
  - busy=0.
  - start=1 -> DATA, counter cleared to 0, shift register preset to all ones.
  - sample_en is ignored in IDLE, including when asserted in the same cycle as start; that strobe is not consumed as a bit.
- DATA:
  - busy=1.
  - Each sample_en=1 cycle shifts in data_in and increments the counter.
  - MSB_FIRST=0: shift right, data_in enters bit DATA_WIDTH-1.
  - MSB_FIRST=1: shift left, data_in enters bit 0.
  - On the sample_en that captures bit DATA_WIDTH-1 (counter==DATA_WIDTH-1):
    - PARITY_EN=1 -> PARITY.
    - PARITY_EN=0 -> completion in the next cycle, then IDLE.
- PARITY:
  - busy=1.
  - The next sample_en captures the parity bit, then completion.
- Completion:
  - Exactly one cycle after the final capturing sample_en: data_out <= assembled word, data_valid=1 for one cycle, state=IDLE, busy=0 in that same cycle.
  - parity_err = (XOR of data bits XOR parity bit) XOR PARITY_ODD; forced 0 when PARITY_EN=0.
- Latency: data_valid rises one clk after the last sample_en of the frame.
- start while busy: ignored; the capture in progress continues unaffected.
- start in the completion cycle: accepted, since the state is already IDLE in that cycle. A back-to-back frame is legal.
- sample_en held high on consecutive cycles: each cycle counts as one bit. No minimum spacing is required.
- Counter width: clog2(DATA_WIDTH+1); never exceeds DATA_WIDTH.
- Reset mid-frame: returns to IDLE immediately. The partial word is discarded, data_out reverts to all ones, and no data_valid is produced.
- data_out and parity_err change only on completion or reset.

Test Plan:
- Defaults (8N, LSB-first): start, then bits 1,0,1,0,0,1,0,1 on 8 sample_en strobes -> data_out=8'hA5 one cycle after the 8th strobe, data_valid one cycle wide, busy low in that cycle, parity_err=0.
- MSB_FIRST=1: same bit stream -> data_out=8'hA5 reversed, i.e. 8'hA5 sent MSB-first as 1,0,1,0,0,1,0,1 yields 8'hA5; sending 0,1,0,1,1,0,1,0 yields 8'h5A.
- PARITY_EN=1, PARITY_ODD=0, DATA_WIDTH=7:
  - Data 7'h41 LSB-first, parity bit 0 -> data_out=7'h41, parity_err=0.
  - Repeat with parity bit 1 -> parity_err=1, data_valid pulses both times.
- Boundary: start and sample_en asserted together, then 8 further strobes of 8'h3C -> first strobe ignored, data_out=8'h3C. Also: start during DATA at bit 4 -> ignored, frame completes normally. Also: start in the completion cycle -> second frame captured correctly.
- Reset mid-frame: after 3 of 8 bits assert reset for 1 cycle -> busy=0, data_out=8'hFF, no data_valid; next full frame of 8'h81 -> data_out=8'h81.
- DATA_WIDTH=9, sample_en held high for 9 consecutive cycles with data_in=1 -> data_out=9'h1FF after exactly 9 strobes, single data_valid.
